// File: rtl/ascii_key_encoder.sv
// ASCII byte stream to PS/2 make/break replay.
// Buffers characters and emits timed ps2_key events.
module ascii_key_encoder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                          pulse,
  input  logic                          reset_n,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          char_ready,
  output logic [10:0]                   ps2_key,
  output logic                          busy,
  output logic                          drop_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int MC = (HOLD_CYCLES > GAP_CYCLES)
                      ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MC + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    RELEASE,
    GAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [7:0]      code;
  logic            mapped;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            nonempty;
  logic [8:0]      head_map;

  // Bit 8 flags a valid mapping; letters fold to lowercase.
  function automatic logic [8:0] map_char(
    input logic [7:0] c
  );
    logic [7:0] k;
    logic [8:0] r;
    k = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    r = 9'h000;
    case (k)
      8'h61: r = 9'h11C;
      8'h62: r = 9'h132;
      8'h63: r = 9'h121;
      8'h64: r = 9'h123;
      8'h65: r = 9'h124;
      8'h66: r = 9'h12B;
      8'h67: r = 9'h134;
      8'h68: r = 9'h133;
      8'h69: r = 9'h143;
      8'h6A: r = 9'h13B;
      8'h6B: r = 9'h142;
      8'h6C: r = 9'h14B;
      8'h6D: r = 9'h13A;
      8'h6E: r = 9'h131;
      8'h6F: r = 9'h144;
      8'h70: r = 9'h14D;
      8'h71: r = 9'h115;
      8'h72: r = 9'h12D;
      8'h73: r = 9'h11B;
      8'h74: r = 9'h12C;
      8'h75: r = 9'h13C;
      8'h76: r = 9'h12A;
      8'h77: r = 9'h11D;
      8'h78: r = 9'h122;
      8'h79: r = 9'h135;
      8'h7A: r = 9'h11A;
      8'h30: r = 9'h145;
      8'h31: r = 9'h116;
      8'h32: r = 9'h11E;
      8'h33: r = 9'h126;
      8'h34: r = 9'h125;
      8'h35: r = 9'h12E;
      8'h36: r = 9'h136;
      8'h37: r = 9'h13D;
      8'h38: r = 9'h13E;
      8'h39: r = 9'h146;
      8'h20: r = 9'h129;
      8'h27: r = 9'h152;
      8'h2A: r = 9'h17C;
      8'h2B: r = 9'h179;
      8'h2C: r = 9'h141;
      8'h2D: r = 9'h14E;
      8'h2E: r = 9'h149;
      8'h2F: r = 9'h14A;
      8'h3B: r = 9'h14C;
      8'h3D: r = 9'h155;
      8'h5C: r = 9'h15D;
      8'h5D: r = 9'h15B;
      8'h60: r = 9'h10E;
      8'h09: r = 9'h10D;
      8'h0A: r = 9'h15A;
      8'h0D: r = 9'h15A;
      8'h1B: r = 9'h176;
      8'h7F: r = 9'h166;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign char_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign nonempty   = (fifo_level != '0);
  assign push       = char_valid && char_ready;
  assign head_map   = map_char(mem[rd_ptr]);
  assign pop        = nonempty &&
                      (state == IDLE ||
                       (state == GAP && cnt == '0));

  // Character storage; no reset needed on the data array.
  always_ff @(posedge pulse) begin
    if (push) mem[wr_ptr] <= char_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge pulse or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_level <= fifo_level + LW'(1);
      else if (pop && !push)
        fifo_level <= fifo_level - LW'(1);
    end
  end

  // Keystroke sequencer with registered outputs.
  always_ff @(posedge pulse or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      code        <= '0;
      mapped      <= 1'b0;
      ps2_key     <= '0;
      drop_strobe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      drop_strobe <= 1'b0;
      busy        <= (state != IDLE) || nonempty;
      case (state)
        IDLE: ;
        PRESS: begin
          if (!mapped) begin
            state <= IDLE;
          end else begin
            ps2_key <= {~ps2_key[10], 2'b10, code};
            if (HOLD_CYCLES == 1) begin
              state <= RELEASE;
            end else begin
              state <= HOLD;
              cnt   <= CW'(HOLD_CYCLES - 2);
            end
          end
        end
        HOLD: begin
          if (cnt == '0) state <= RELEASE;
          else cnt <= cnt - CW'(1);
        end
        RELEASE: begin
          ps2_key <= {~ps2_key[10], 2'b00, code};
          state   <= GAP;
          cnt     <= CW'(GAP_CYCLES - 1);
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
        code        <= head_map[7:0];
        mapped      <= head_map[8];
        drop_strobe <= ~head_map[8];
        state       <= PRESS;
      end
    end
  end

endmodule

// File: tb/tb_ascii_key_encoder.sv
// Scoreboard bench for ascii_key_encoder.
// Expected events queued on accept, popped on output.
`timescale 1ns/1ps
module tb_ascii_key_encoder;

  logic        pulse = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [10:0] ps2_key;
  logic        busy;
  logic        drop_strobe;
  logic [4:0]  fifo_level;

  int total = 0;
  int bad = 0;

  logic [8:0]  lut [256];
  logic [9:0]  exp_q [$];
  int          press_q [$];
  int          rel_q [$];
  int          events = 0;
  int          drops = 0;
  int          drop_edge = -1;
  int          busy_fall = -1;
  int          max_level = 0;
  logic [10:0] prev_key = '0;
  logic        prev_busy = 1'b0;

  logic [7:0] lt [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A};
  logic [7:0] dg [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [15:0] pp [18] = '{
    16'h2029, 16'h2752, 16'h2A7C, 16'h2B79,
    16'h2C41, 16'h2D4E, 16'h2E49, 16'h2F4A,
    16'h3B4C, 16'h3D55, 16'h5C5D, 16'h5D5B,
    16'h600E, 16'h090D, 16'h0A5A, 16'h0D5A,
    16'h1B76, 16'h7F66};

  ascii_key_encoder dut (
    .pulse       (pulse),
    .reset_n     (reset_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .ps2_key     (ps2_key),
    .busy        (busy),
    .drop_strobe (drop_strobe),
    .fifo_level  (fifo_level)
  );

  always #5 pulse = ~pulse;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, got, want);
    end
  endtask

  task automatic expect_char(input logic [7:0] c);
    if (lut[c][8]) begin
      exp_q.push_back({2'b10, lut[c][7:0]});
      exp_q.push_back({2'b00, lut[c][7:0]});
    end else begin
      exp_q.push_back(10'h3FF);
    end
  endtask

  task automatic send(input logic [7:0] c,
                      output int e);
    int n;
    n = 0;
    while (!char_ready && n < 300) begin
      @(negedge pulse);
      n++;
    end
    if (n >= 300) chk("send_wait", n, 0);
    char_in = c;
    char_valid = 1'b1;
    expect_char(c);
    @(posedge pulse);
    e = int'(($time - 5) / 10);
    @(negedge pulse);
    char_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0 ||
            fifo_level != 0) && n < 4000) begin
      @(negedge pulse);
      n++;
    end
    if (n >= 4000) chk("drain_wait", n, 0);
    @(negedge pulse);
  endtask

  task automatic wait_press();
    int n;
    n = 0;
    while (!ps2_key[9] && n < 100) begin
      @(negedge pulse);
      n++;
    end
    if (n >= 100) chk("press_wait", n, 0);
  endtask

  always @(negedge pulse) begin
    int e;
    logic [9:0] w;
    e = int'($time / 10) - 1;
    if (!reset_n) begin
      prev_key = '0;
      prev_busy = 1'b0;
    end else begin
      chk("ready", char_ready, fifo_level != 5'd16);
      if (int'(fifo_level) > max_level)
        max_level = int'(fifo_level);
      if (ps2_key != prev_key) begin
        events++;
        chk("toggle", ps2_key[10] ^ prev_key[10], 1);
        chk("chg_drop", drop_strobe, 0);
        if (exp_q.size() == 0) begin
          chk("unexp_evt", 0, 1);
        end else begin
          w = exp_q.pop_front();
          chk("evt", ps2_key[9:0], w);
        end
        if (ps2_key[9]) press_q.push_back(e);
        else rel_q.push_back(e);
        prev_key = ps2_key;
      end
      if (drop_strobe) begin
        drops++;
        drop_edge = e;
        if (exp_q.size() == 0) begin
          chk("unexp_drop", 0, 1);
        end else begin
          w = exp_q.pop_front();
          chk("drop", w, 10'h3FF);
        end
      end
      if (prev_busy && !busy) busy_fall = e;
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

  initial begin
    int e0;
    int e1;
    int ev0;
    int d0;
    int nun;

    for (int i = 0; i < 256; i++) lut[i] = '0;
    for (int i = 0; i < 26; i++) begin
      lut[8'h61 + i] = {1'b1, lt[i]};
      lut[8'h41 + i] = {1'b1, lt[i]};
    end
    for (int i = 0; i < 10; i++)
      lut[8'h30 + i] = {1'b1, dg[i]};
    for (int i = 0; i < 18; i++)
      lut[pp[i][15:8]] = {1'b1, pp[i][7:0]};

    #1 reset_n = 1'b0;
    repeat (2) @(negedge pulse);
    chk("rst_key", ps2_key, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_rdy", char_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_strobe, 0);
    #2 reset_n = 1'b1;
    @(negedge pulse);

    press_q.delete();
    rel_q.delete();
    ev0 = events;
    send(8'h61, e0);
    chk("lvl_push", fifo_level, 1);
    @(negedge pulse);
    chk("lvl_pop", fifo_level, 0);
    drain();
    chk("a_press", press_q[0] - e0, 2);
    chk("a_rel", rel_q[0] - e0, 10);
    chk("a_busy", busy_fall - e0, 19);
    chk("a_evts", events - ev0, 2);

    press_q.delete();
    send(8'h48, e0);
    send(8'h69, e1);
    drain();
    chk("hi_n", press_q.size(), 2);
    chk("hi_gap", press_q[1] - press_q[0], 17);

    press_q.delete();
    d0 = drops;
    send(8'h40, e0);
    send(8'h31, e1);
    drain();
    chk("at_drops", drops - d0, 1);
    chk("one_lat", press_q[0] - drop_edge, 3);

    press_q.delete();
    max_level = 0;
    for (int i = 0; i < 20; i++)
      send(8'(8'h61 + i), e0);
    drain();
    chk("full_seen", max_level, 16);
    chk("fill_n", press_q.size(), 20);

    send(8'h7A, e0);
    send(8'h71, e1);
    wait_press();
    chk("z_press", ps2_key[9:0], 10'h21A);
    repeat (3) @(negedge pulse);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_key", ps2_key, 0);
    chk("arst_lvl", fifo_level, 0);
    exp_q.delete();
    ev0 = events;
    repeat (2) @(negedge pulse);
    #2 reset_n = 1'b1;
    repeat (30) @(negedge pulse);
    chk("no_rel", events - ev0, 0);
    chk("key_idle", ps2_key, 0);
    send(8'h0A, e0);
    wait_press();
    chk("lf_press", ps2_key, 11'h65A);
    drain();

    d0 = drops;
    ev0 = events;
    nun = 0;
    for (int c = 0; c < 256; c++) begin
      if (!lut[c][8]) nun++;
      send(8'(c), e0);
    end
    drain();
    chk("sweep_drops", drops - d0, nun);
    chk("sweep_evts", events - ev0, 2 * (256 - nun));
    chk("sweep_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
